// File: rtl/proc_ctx_pkg.sv
// Shared types and helpers for the process-context unit.
//   state_t       : load FSM states (IDLE, LOAD)
//   OS_PID        : process id reserved for the OS (slot 0)
//   proc_id_width : width of a process id for a given slot count
//   cmd_t         : OS-control flags decoded from the opcode
package proc_ctx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam int unsigned OS_PID = 0;

    function automatic int unsigned proc_id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic getpc;
        logic setpc;
        logic sprc;
        logic chwrt;
        logic chrd;
    } cmd_t;

endpackage

// File: rtl/proc_ctx_slots.sv
// Saved-PC register file: NUM_PROCS entries of PC_W bits.
// Ports:
//   clock, reset  : clock and synchronous active-high reset (clears all slots)
//   we/waddr/wdata: single write port
//   raddr/rdata   : single asynchronous read port (returns the pre-write value
//                   when read and write hit the same slot in one cycle)
module proc_ctx_slots #(
    parameter int unsigned NUM_PROCS = 4,
    parameter int unsigned PC_W      = 10,
    parameter int unsigned ID_W      = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            we,
    input  logic [ID_W-1:0] waddr,
    input  logic [PC_W-1:0] wdata,
    input  logic [ID_W-1:0] raddr,
    output logic [PC_W-1:0] rdata
);

    logic [PC_W-1:0] mem [NUM_PROCS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PROCS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/proc_ctx_unit.sv
// Process-context unit: responds to the OS-control opcode flags (getpc,
// setpc, sprc, chwrt, chrd), keeps per-process saved PCs, the current
// process id and the instruction-memory shift registers, and issues
// one-cycle PC-load requests.
// Optional round-robin preemption is built when PROC_CTX_PREEMPT_EN is
// defined; otherwise preempt is tied low and only setpc loads the PC.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   save_proc_pc          : slot[reg_data] <= pc_in + 1
//   change_proc_pc        : pc_out <= slot[reg_data], pc_load next cycle
//   proc_swap             : cur_proc <= reg_data
//   chng_wrt_shft/rd_shft : wrt_shift / rd_shift <= reg_data[SHIFT_W-1:0]
//   hlt, instr_step       : quantum timer qualifiers
//   pc_in, reg_data       : current PC, register-file operand
//   pc_load, pc_out       : PC load request and target
//   cur_proc              : running process id
//   wrt_shift, rd_shift   : instruction-memory offsets
//   preempt               : pulse in the cycle a quantum expires
//   idx_err               : sticky out-of-range slot index
//   busy                  : FSM in LOAD
module proc_ctx_unit
    import proc_ctx_pkg::*;
#(
    parameter int unsigned NUM_PROCS = 4,
    parameter int unsigned PC_W      = 10,
    parameter int unsigned SHIFT_W   = 10,
    parameter int unsigned QUANTUM   = 64,
    parameter int unsigned OS_ENTRY  = 0,
    localparam int unsigned PROC_ID_W = proc_id_width(NUM_PROCS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 save_proc_pc,
    input  logic                 change_proc_pc,
    input  logic                 proc_swap,
    input  logic                 chng_wrt_shft,
    input  logic                 chng_rd_shft,
    input  logic                 hlt,
    input  logic                 instr_step,
    input  logic [PC_W-1:0]      pc_in,
    input  logic [31:0]          reg_data,
    output logic                 pc_load,
    output logic [PC_W-1:0]      pc_out,
    output logic [PROC_ID_W-1:0] cur_proc,
    output logic [SHIFT_W-1:0]   wrt_shift,
    output logic [SHIFT_W-1:0]   rd_shift,
    output logic                 preempt,
    output logic                 idx_err,
    output logic                 busy
);

    cmd_t                 cmd;
    state_t               state;
    logic                 idx_ok;
    logic [PROC_ID_W-1:0] idx;
    logic                 getpc_ok;
    logic                 setpc_ok;
    logic                 sprc_ok;
    logic                 any_cmd;
    logic                 expire;
    logic [PC_W-1:0]      pc_next;
    logic                 slot_we;
    logic [PROC_ID_W-1:0] slot_waddr;
    logic [PC_W-1:0]      slot_rdata;

    assign cmd = '{getpc: save_proc_pc, setpc: change_proc_pc, sprc: proc_swap,
                   chwrt: chng_wrt_shft, chrd: chng_rd_shft};

    // Full 32-bit compare so high operand bits cannot alias onto a valid slot.
    assign idx_ok   = reg_data < 32'(NUM_PROCS);
    assign idx      = reg_data[PROC_ID_W-1:0];
    assign getpc_ok = cmd.getpc && idx_ok;
    assign setpc_ok = cmd.setpc && idx_ok && (state == IDLE);
    assign sprc_ok  = cmd.sprc && idx_ok;
    assign any_cmd  = |cmd;
    assign pc_next  = pc_in + PC_W'(1);

`ifdef PROC_CTX_PREEMPT_EN
    localparam int unsigned    Q_W    = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [Q_W-1:0] Q_LAST = Q_W'(QUANTUM - 1);

    logic [Q_W-1:0] qcnt;
    logic           in_user;
    logic           step_q;

    assign in_user = cur_proc != PROC_ID_W'(OS_PID);
    assign step_q  = instr_step && !hlt && in_user;
    // Any command or an in-flight load defers expiry; the counter then sits
    // at Q_LAST so the next qualifying step retries.
    assign expire  = !reset && step_q && (qcnt == Q_LAST) && !any_cmd && (state == IDLE);
    assign preempt = expire;

    always_ff @(posedge clock) begin
        if (reset) begin
            qcnt <= '0;
        end else if (sprc_ok || expire || !in_user) begin
            qcnt <= '0;
        end else if (step_q && (qcnt != Q_LAST)) begin
            qcnt <= qcnt + Q_W'(1);
        end
    end
`else
    logic unused_nopreempt;

    assign expire           = 1'b0;
    assign preempt          = 1'b0;
    assign unused_nopreempt = ^{hlt, instr_step, (QUANTUM != 0), (OS_ENTRY != 0)};
`endif

    // getpc and the preemption save never coincide (a command blocks expiry),
    // so one write port serves both.
    assign slot_we    = getpc_ok || expire;
    assign slot_waddr = getpc_ok ? idx : cur_proc;

    proc_ctx_slots #(
        .NUM_PROCS (NUM_PROCS),
        .PC_W      (PC_W),
        .ID_W      (PROC_ID_W)
    ) u_slots (
        .clock (clock),
        .reset (reset),
        .we    (slot_we),
        .waddr (slot_waddr),
        .wdata (pc_next),
        .raddr (idx),
        .rdata (slot_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pc_out    <= '0;
            cur_proc  <= '0;
            wrt_shift <= '0;
            rd_shift  <= '0;
            idx_err   <= 1'b0;
        end else begin
            state <= ((state == IDLE) && (setpc_ok || expire)) ? LOAD : IDLE;

            if (setpc_ok) begin
                pc_out <= slot_rdata;
            end else if (expire) begin
                pc_out <= PC_W'(OS_ENTRY);
            end

            if (sprc_ok) begin
                cur_proc <= idx;
            end else if (expire) begin
                cur_proc <= PROC_ID_W'(OS_PID);
            end

            if (cmd.chwrt) begin
                wrt_shift <= reg_data[SHIFT_W-1:0];
            end
            if (cmd.chrd) begin
                rd_shift <= reg_data[SHIFT_W-1:0];
            end

            if ((cmd.getpc || cmd.setpc || cmd.sprc) && !idx_ok) begin
                idx_err <= 1'b1;
            end
        end
    end

    assign pc_load = (state == LOAD);
    assign busy    = (state == LOAD);

endmodule

// File: tb/tb_proc_ctx_unit.sv
// Self-checking bench for proc_ctx_unit. Stimulus pushes expected pc_load
// and preempt events (value + cycle) into queues; a negedge monitor pops and
// compares them whenever the DUT raises pc_load or preempt. Register-style
// outputs are checked directly one step after the sampling edge.
// Preemption scenarios are compiled in when PROC_CTX_PREEMPT_EN is defined.
module tb_proc_ctx_unit;

    localparam int unsigned PC_W = 10;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              save_proc_pc = 1'b0;
    logic              change_proc_pc = 1'b0;
    logic              proc_swap = 1'b0;
    logic              chng_wrt_shft = 1'b0;
    logic              chng_rd_shft = 1'b0;
    logic              hlt = 1'b0;
    logic              instr_step = 1'b0;
    logic [PC_W-1:0]   pc_in = '0;
    logic [31:0]       reg_data = '0;
    logic              pc_load;
    logic [PC_W-1:0]   pc_out;
    logic [1:0]        cur_proc;
    logic [9:0]        wrt_shift;
    logic [9:0]        rd_shift;
    logic              preempt;
    logic              idx_err;
    logic              busy;

    proc_ctx_unit #(
        .NUM_PROCS (4),
        .PC_W      (PC_W),
        .SHIFT_W   (10),
        .QUANTUM   (4),
        .OS_ENTRY  (0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .save_proc_pc   (save_proc_pc),
        .change_proc_pc (change_proc_pc),
        .proc_swap      (proc_swap),
        .chng_wrt_shft  (chng_wrt_shft),
        .chng_rd_shft   (chng_rd_shft),
        .hlt            (hlt),
        .instr_step     (instr_step),
        .pc_in          (pc_in),
        .reg_data       (reg_data),
        .pc_load        (pc_load),
        .pc_out         (pc_out),
        .cur_proc       (cur_proc),
        .wrt_shift      (wrt_shift),
        .rd_shift       (rd_shift),
        .preempt        (preempt),
        .idx_err        (idx_err),
        .busy           (busy)
    );

    typedef struct {
        int unsigned val;
        int          cyc;
    } exp_t;

    exp_t        exp_load[$];
    exp_t        exp_pre[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int unsigned slot2_model = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cmd(input logic g, input logic s, input logic p, input logic w, input logic r,
                       input logic [31:0] d, input logic [PC_W-1:0] pc);
        save_proc_pc   = g;
        change_proc_pc = s;
        proc_swap      = p;
        chng_wrt_shft  = w;
        chng_rd_shft   = r;
        reg_data       = d;
        pc_in          = pc;
        tick();
        save_proc_pc   = 1'b0;
        change_proc_pc = 1'b0;
        proc_swap      = 1'b0;
        chng_wrt_shft  = 1'b0;
        chng_rd_shft   = 1'b0;
    endtask

    task automatic step(input logic [PC_W-1:0] pc, input logic h);
        instr_step = 1'b1;
        hlt        = h;
        pc_in      = pc;
        tick();
        instr_step = 1'b0;
        hlt        = 1'b0;
    endtask

    // Expected load appears in the cycle after the command is sampled.
    task automatic push_load(input int unsigned v);
        exp_load.push_back('{val: v, cyc: cyc + 1});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc_load"},   32'(pc_load),   0);
        check({tag, "_pc_out"},    32'(pc_out),    0);
        check({tag, "_cur_proc"},  32'(cur_proc),  0);
        check({tag, "_wrt_shift"}, 32'(wrt_shift), 0);
        check({tag, "_rd_shift"},  32'(rd_shift),  0);
        check({tag, "_preempt"},   32'(preempt),   0);
        check({tag, "_idx_err"},   32'(idx_err),   0);
        check({tag, "_busy"},      32'(busy),      0);
    endtask

    always @(negedge clock) begin
        if (pc_load === 1'b1) begin
            checks++;
            if (exp_load.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pc_load pc_out=%0d cycle=%0d", pc_out, cyc);
            end else begin
                exp_t e;
                e = exp_load.pop_front();
                if (pc_out !== PC_W'(e.val) || cyc != e.cyc || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL pc_load_event got pc_out=%0d cycle=%0d busy=%b expected pc_out=%0d cycle=%0d busy=1",
                             pc_out, cyc, busy, e.val, e.cyc);
                end
            end
        end else if (exp_load.size() != 0 && exp_load[0].cyc < cyc) begin
            exp_t e;
            e = exp_load.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pc_load got none expected pc_out=%0d at cycle=%0d", e.val, e.cyc);
        end

        if (preempt === 1'b1) begin
            checks++;
            if (exp_pre.size() == 0) begin
                errors++;
                $display("FAIL unexpected_preempt cur_proc=%0d cycle=%0d", cur_proc, cyc);
            end else begin
                exp_t e;
                e = exp_pre.pop_front();
                if (cur_proc !== 2'(e.val) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL preempt_event got cur_proc=%0d cycle=%0d expected cur_proc=%0d cycle=%0d",
                             cur_proc, cyc, e.val, e.cyc);
                end
            end
        end else if (exp_pre.size() != 0 && exp_pre[0].cyc < cyc) begin
            exp_t e;
            e = exp_pre.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_preempt got none expected cur_proc=%0d at cycle=%0d", e.val, e.cyc);
        end
    end

    initial begin
        repeat (3) tick();
        check_reset_state("rst");
        reset = 1'b0;

        // getpc slot2 <= 37+1, then setpc slot2
        cmd(1, 0, 0, 0, 0, 2, 37);
        slot2_model = 38;
        push_load(38);
        cmd(0, 1, 0, 0, 0, 2, 0);
        check("busy_in_load", 32'(busy), 1);
        tick();
        check("pc_load_drop", 32'(pc_load), 0);
        check("pc_out_hold", 32'(pc_out), 38);

        // multiple flags in one cycle share reg_data
        cmd(0, 0, 1, 1, 1, 3, 0);
        check("multi_cur_proc", 32'(cur_proc), 3);
        check("multi_wrt", 32'(wrt_shift), 3);
        check("multi_rd", 32'(rd_shift), 3);
        cmd(0, 0, 1, 1, 0, 1, 0);
        cmd(0, 0, 0, 1, 0, 200, 0);
        cmd(0, 0, 0, 0, 1, 300, 0);
        check("sprc_cur_proc", 32'(cur_proc), 1);
        check("chwrt_200", 32'(wrt_shift), 200);
        check("chrd_300", 32'(rd_shift), 300);
        cmd(0, 0, 0, 1, 0, 32'h0001_0405, 0);
        check("chwrt_trunc", 32'(wrt_shift), 5);

        // out-of-range setpc: no load, sticky idx_err
        cmd(0, 1, 0, 0, 0, 7, 0);
        check("idx_err_set", 32'(idx_err), 1);
        check("bad_setpc_no_load", 32'(pc_load), 0);
        push_load(38);
        cmd(0, 1, 0, 0, 0, 2, 0);
        tick();
        check("idx_err_sticky", 32'(idx_err), 1);

        // getpc wraps 1023+1 -> 0
        cmd(1, 0, 0, 0, 0, 3, 1023);
        push_load(0);
        cmd(0, 1, 0, 0, 0, 3, 0);
        tick();

        // same-cycle getpc/setpc on slot2: setpc sees old value
        push_load(38);
        cmd(1, 1, 0, 0, 0, 2, 500);
        slot2_model = 501;
        tick();
        push_load(501);
        cmd(0, 1, 0, 0, 0, 2, 0);
        tick();

        // setpc while busy is ignored
        push_load(0);
        cmd(0, 1, 0, 0, 0, 3, 0);
        cmd(0, 1, 0, 0, 0, 2, 0);
        check("busy_setpc_ignored", 32'(pc_out), 0);
        tick();

        // out-of-range getpc / sprc have no effect
        cmd(1, 0, 0, 0, 0, 4, 77);
        cmd(0, 0, 1, 0, 0, 6, 0);
        check("bad_sprc_no_effect", 32'(cur_proc), 1);
        push_load(0);
        cmd(0, 1, 0, 0, 0, 0, 0);
        tick();

`ifdef PROC_CTX_PREEMPT_EN
        // quantum expiry on the 4th step of process 2
        cmd(0, 0, 1, 0, 0, 2, 0);
        step(100, 0);
        step(101, 0);
        step(102, 0);
        exp_pre.push_back('{val: 2, cyc: cyc});
        push_load(0);
        step(103, 0);
        check("preempt_cur_proc", 32'(cur_proc), 0);
        tick();
        slot2_model = 104;
        push_load(104);
        cmd(0, 1, 0, 0, 0, 2, 0);
        tick();

        // halted steps do not count
        cmd(0, 0, 1, 0, 0, 1, 0);
        repeat (10) step(200, 1);
        step(201, 0);
        step(202, 0);
        step(203, 0);
        exp_pre.push_back('{val: 1, cyc: cyc});
        push_load(0);
        step(204, 0);
        tick();

        // expiry coinciding with chwrt is deferred to the next step
        cmd(0, 0, 1, 0, 0, 3, 0);
        step(300, 0);
        step(301, 0);
        step(302, 0);
        instr_step = 1'b1;
        cmd(0, 0, 0, 1, 0, 55, 303);
        instr_step = 1'b0;
        check("deferred_wrt", 32'(wrt_shift), 55);
        check("deferred_cur_proc", 32'(cur_proc), 3);
        exp_pre.push_back('{val: 3, cyc: cyc});
        push_load(0);
        step(304, 0);
        tick();
        push_load(305);
        cmd(0, 1, 0, 0, 0, 3, 0);
        tick();
`endif

        // reset in the middle of a load
        push_load(slot2_model);
        cmd(0, 1, 0, 0, 0, 2, 0);
        reset = 1'b1;
        tick();
        check_reset_state("midload");
        reset = 1'b0;
        push_load(0);
        cmd(0, 1, 0, 0, 0, 2, 0);
        tick();
        tick();

        check("load_queue_drain", 32'(exp_load.size()), 0);
        check("preempt_queue_drain", 32'(exp_pre.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
